elevator_car_controller: RTL and testbench

// Top-level car sequencer for one elevator car. Latches floor calls into a

---
 rtl/elevator_car_controller.sv | 149 ++++++++++++++
 tb/tb_elevator_car_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_controller.sv
// Single-car sequencer: latches floor calls, steps the car one floor at a time
// using the external resolver's direction answer, and holds the door at each stop.
module elevator_car_controller #(
    parameter int NUM_FLOORS    = 7,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [NUM_FLOORS-1:0] queue_status,
    output logic [2:0]            current_floor,
    output logic                  current_up_ndown,
    input  logic                  next_up_ndown,
    input  logic                  queue_empty,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [2:0]    TOP_FLOOR   = 3'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         travel_timer_reg, travel_timer_next;
    logic [DW-1:0]         door_timer_reg, door_timer_next;
    logic [NUM_FLOORS-1:0] queue_reg, queue_next;
    logic [2:0]            floor_reg, floor_next;
    logic                  dir_reg, dir_next;
    logic                  arrive_reg, arrive_next;

    logic here_called;
    logic call_here;
    logic dir_allowed;
    logic step_up;
    logic clear_here;

    assign here_called = queue_reg[floor_reg];
    assign call_here   = call_req[floor_reg];

    // The resolver's answer is overridden at the shaft ends so the car can never leave range.
    assign dir_allowed = (floor_reg == 3'd0)      ? 1'b1 :
                         (floor_reg == TOP_FLOOR) ? 1'b0 : next_up_ndown;

    always_comb begin
        state_next        = state_reg;
        travel_timer_next = travel_timer_reg;
        door_timer_next   = door_timer_reg;
        floor_next        = floor_reg;
        dir_next          = dir_reg;
        arrive_next       = 1'b0;
        step_up           = dir_reg;
        case (state_reg)
            IDLE: begin
                if (here_called) begin
                    state_next      = DOOR;
                    door_timer_next = '0;
                end else if (!queue_empty) begin
                    dir_next          = dir_allowed;
                    travel_timer_next = '0;
                    state_next        = MOVE;
                end
            end
            MOVE: begin
                // arrive_reg marks the first cycle on a new floor: the only point a stop is decided.
                if (arrive_reg && here_called) begin
                    state_next        = DOOR;
                    door_timer_next   = '0;
                    travel_timer_next = '0;
                end else if (arrive_reg && queue_empty) begin
                    state_next        = IDLE;
                    travel_timer_next = '0;
                end else begin
                    if (arrive_reg) begin
                        dir_next = dir_allowed;
                        step_up  = dir_allowed;
                    end
                    if (travel_timer_reg == TRAVEL_LAST) begin
                        travel_timer_next = '0;
                        arrive_next       = 1'b1;
                        floor_next        = step_up ? floor_reg + 3'd1 : floor_reg - 3'd1;
                    end else begin
                        travel_timer_next = travel_timer_reg + TW'(1);
                    end
                end
            end
            DOOR: begin
                if (call_here) begin
                    door_timer_next = '0;
                end else if (door_timer_reg == DOOR_LAST) begin
                    state_next      = IDLE;
                    door_timer_next = '0;
                end else begin
                    door_timer_next = door_timer_reg + DW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A call for the floor whose door is open (or opening) is absorbed rather than queued.
    assign clear_here = (state_next == DOOR) || (state_reg == DOOR);

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_queue
            assign queue_next[gi] = (clear_here && (floor_reg == 3'(gi))) ? 1'b0
                                    : (queue_reg[gi] | call_req[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            travel_timer_reg <= '0;
            door_timer_reg   <= '0;
            queue_reg        <= '0;
            floor_reg        <= 3'd0;
            dir_reg          <= 1'b1;
            arrive_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            travel_timer_reg <= travel_timer_next;
            door_timer_reg   <= door_timer_next;
            queue_reg        <= queue_next;
            floor_reg        <= floor_next;
            dir_reg          <= dir_next;
            arrive_reg       <= arrive_next;
        end
    end

    assign queue_status     = queue_reg;
    assign current_floor    = floor_reg;
    assign current_up_ndown = dir_reg;
    assign moving           = (state_reg == MOVE);
    assign door_open        = (state_reg == DOOR);
    assign arrive           = arrive_reg;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Lockstep bench for elevator_car_controller: directed scenarios plus random calls,
// every cycle compared against a countdown-based reference of the car's behaviour.
module tb_elevator_car_controller;

    localparam int NF = 7;
    localparam int TC = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] call_req;
    logic [NF-1:0] queue_status;
    logic [2:0]    current_floor;
    logic          current_up_ndown;
    logic          next_up_ndown;
    logic          queue_empty;
    logic          moving;
    logic          door_open;
    logic          arrive;

    always #5 clk = ~clk;

    elevator_car_controller #(
        .NUM_FLOORS   (NF),
        .TRAVEL_CYCLES(TC),
        .DOOR_CYCLES  (DC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .call_req        (call_req),
        .queue_status    (queue_status),
        .current_floor   (current_floor),
        .current_up_ndown(current_up_ndown),
        .next_up_ndown   (next_up_ndown),
        .queue_empty     (queue_empty),
        .moving          (moving),
        .door_open       (door_open),
        .arrive          (arrive)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: travel_left = cycles until the next floor change, door_left = door cycles remaining.
    int            m_floor       = 0;
    logic [NF-1:0] m_queue       = '0;
    logic          m_dir         = 1'b1;
    logic          m_arrive      = 1'b0;
    int            m_travel_left = 0;
    int            m_door_left   = 0;
    bit            m_valid       = 1'b0;

    bit   chaos    = 1'b0;
    bit   perverse = 1'b0;
    int   cnt_door, cnt_arrive, cnt_move;
    int   door_log[$];
    logic prev_door = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [NF-1:0] onehot(input int f);
        logic [NF-1:0] v;
        v    = '0;
        v[f] = 1'b1;
        return v;
    endfunction

    function automatic logic bound_dir(input int f, input logic want);
        if (f == 0) return 1'b1;
        if (f == NF - 1) return 1'b0;
        return want;
    endfunction

    // External resolver: keep going while calls lie ahead, otherwise turn towards any call.
    function automatic logic resolve();
        logic above, below;
        above = 1'b0;
        below = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (m_queue[f] && f > m_floor) above = 1'b1;
            if (m_queue[f] && f < m_floor) below = 1'b1;
        end
        if (perverse && m_floor == 0) return 1'b0;
        if (perverse && m_floor == NF - 1) return 1'b1;
        if (chaos && ($urandom % 4 == 0)) return 1'($urandom % 2);
        if (m_dir && above) return 1'b1;
        if (!m_dir && below) return 1'b0;
        if (above) return 1'b1;
        if (below) return 1'b0;
        return m_dir;
    endfunction

    task automatic model_step(input logic [NF-1:0] calls, input logic r, input logic nu, input logic qe);
        logic          clear, dn, an;
        logic [NF-1:0] qn;
        int            tl, dl, fl;
        bit            deciding, go;
        if (r) begin
            m_floor = 0; m_queue = '0; m_dir = 1'b1; m_arrive = 1'b0;
            m_travel_left = 0; m_door_left = 0; m_valid = 1'b1;
            return;
        end
        clear = 1'b0; tl = m_travel_left; dl = m_door_left; fl = m_floor; dn = m_dir; an = 1'b0;
        if (m_door_left > 0) begin
            clear = 1'b1;
            dl    = calls[m_floor] ? DC : m_door_left - 1;
        end else begin
            deciding = (m_travel_left == 0) || m_arrive;
            go       = (m_travel_left > 0);
            if (deciding) begin
                if (m_queue[m_floor]) begin
                    dl = DC; tl = 0; clear = 1'b1; go = 1'b0;
                end else if (qe) begin
                    tl = 0; go = 1'b0;
                end else begin
                    dn = bound_dir(m_floor, nu);
                    if (m_travel_left == 0) begin
                        tl = TC; go = 1'b0;
                    end
                end
            end
            if (go) begin
                if (m_travel_left == 1) begin
                    fl = dn ? m_floor + 1 : m_floor - 1;
                    an = 1'b1;
                    tl = TC;
                end else begin
                    tl = m_travel_left - 1;
                end
            end
        end
        qn = m_queue | calls;
        if (clear) qn[m_floor] = 1'b0;
        m_queue = qn; m_floor = fl; m_dir = dn; m_arrive = an;
        m_travel_left = tl; m_door_left = dl;
    endtask

    // One clock cycle: compare outputs at the negedge, drive this cycle's inputs, advance the model.
    task automatic tick(input logic [NF-1:0] calls, input logic r);
        logic nu, qe;
        if (m_valid) begin
            check("queue_status", queue_status, m_queue);
            check("current_floor", current_floor, m_floor);
            check("current_up_ndown", current_up_ndown, m_dir);
            check("moving", moving, m_travel_left > 0);
            check("door_open", door_open, m_door_left > 0);
            check("arrive", arrive, m_arrive);
            check("moving_door_excl", moving & door_open, 0);
        end
        if (door_open && !prev_door) door_log.push_back(int'(current_floor));
        prev_door = door_open;
        cnt_door   += int'(door_open);
        cnt_arrive += int'(arrive);
        cnt_move   += int'(moving);
        nu = resolve();
        qe = (m_queue == '0);
        rst           = r;
        call_req      = calls;
        next_up_ndown = nu;
        queue_empty   = qe;
        model_step(calls, r, nu, qe);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick('0, 1'b0);
    endtask

    task automatic do_reset();
        tick('0, 1'b1);
        tick('0, 1'b1);
        cnt_door = 0; cnt_arrive = 0; cnt_move = 0;
        door_log.delete();
    endtask

    initial begin
        int            guard;
        logic [NF-1:0] calls;
        rst = 1'b1; call_req = '0; next_up_ndown = 1'b1; queue_empty = 1'b1;
        @(negedge clk);

        do_reset();
        check("reset_floor", current_floor, 0);
        check("reset_queue", queue_status, 0);
        check("reset_moving", moving, 0);
        check("reset_door", door_open, 0);
        check("reset_arrive", arrive, 0);
        check("reset_dir", current_up_ndown, 1);

        // Call floor 3 from floor 0.
        tick(onehot(3), 1'b0);
        run(40);
        check("f3_arrives", cnt_arrive, 3);
        check("f3_door_cycles", cnt_door, DC);
        check("f3_floor", current_floor, 3);
        check("f3_queue", queue_status, 0);

        // Call the floor the car is already idle on.
        do_reset();
        tick(onehot(0), 1'b0);
        run(15);
        check("f0_move_cycles", cnt_move, 0);
        check("f0_door_cycles", cnt_door, DC);
        check("f0_queue", queue_status, 0);

        // Moving down through floor 4 with calls at 1 and 6.
        do_reset();
        tick(onehot(5), 1'b0);
        run(40);
        tick(onehot(1), 1'b0);
        guard = 0;
        while (!(m_floor == 4 && m_travel_left > 0) && guard < 200) begin
            tick('0, 1'b0);
            guard++;
        end
        check("wait_floor4", guard < 200, 1);
        tick(onehot(6), 1'b0);
        run(80);
        check("scan_stops", door_log.size(), 3);
        check("scan_first_stop", door_log[1], 1);
        check("scan_second_stop", door_log[2], 6);

        // Resolver points out of the shaft at both ends; the car must turn anyway.
        perverse = 1'b1;
        tick(onehot(0), 1'b0);
        run(60);
        check("bound_reach_0", current_floor, 0);
        tick(onehot(6), 1'b0);
        run(60);
        check("bound_reach_6", current_floor, 6);
        perverse = 1'b0;

        // Re-call during the second door cycle holds the door.
        do_reset();
        tick(onehot(2), 1'b0);
        guard = 0;
        while (m_door_left != DC - 1 && guard < 200) begin
            tick('0, 1'b0);
            guard++;
        end
        check("wait_door", guard < 200, 1);
        tick(onehot(m_floor), 1'b0);
        run(15);
        check("held_door_cycles", cnt_door, 5);
        check("held_queue", queue_status, 0);

        // Reset between floors 2 and 3 drops everything.
        do_reset();
        tick(onehot(5) | onehot(4), 1'b0);
        guard = 0;
        while (!(m_floor == 2 && m_travel_left == 2) && guard < 200) begin
            tick('0, 1'b0);
            guard++;
        end
        check("wait_mid_move", guard < 200, 1);
        check("mid_move_moving", moving, 1);
        tick('0, 1'b1);
        check("midrst_floor", current_floor, 0);
        check("midrst_queue", queue_status, 0);
        check("midrst_moving", moving, 0);
        check("midrst_door", door_open, 0);
        check("midrst_arrive", arrive, 0);
        check("midrst_dir", current_up_ndown, 1);

        // Random calls, occasionally erratic resolver answers and resets.
        chaos = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            calls = ($urandom % 6 == 0) ? onehot(int'($urandom % NF)) : '0;
            if ($urandom % 40 == 0) calls = NF'($urandom);
            tick(calls, 1'($urandom % 400 == 0));
        end
        chaos = 1'b0;
        run(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
